// File: rtl/wb_result_buffer.sv
// In-order result FIFO between an execution unit's final stage and the writeback arbiter.
// The head entry is presented as wb_done/wb_id/wb_rd; a one-cycle wb_ack pops it.
module wb_result_buffer #(
   parameter int DEPTH = 2,
   parameter int ID_W  = 4,
   parameter int XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         result_valid,
   input  logic [ID_W-1:0]              result_id,
   input  logic [XLEN-1:0]              result_data,
   output logic                         result_ready,
   output logic                         wb_done,
   output logic [ID_W-1:0]              wb_id,
   output logic [XLEN-1:0]              wb_rd,
   input  logic                         wb_ack,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [ID_W-1:0] r_id_mem   [DEPTH];
   logic [XLEN-1:0] r_data_mem [DEPTH];
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;

   logic w_push;
   logic w_pop;

   // Ready depends only on registered occupancy, so a full buffer refuses
   // an offer even on the cycle its head is being acked.
   assign result_ready = (r_count != FULL_COUNT);
   assign wb_done      = (r_count != '0);
   assign wb_id        = r_id_mem[r_rd_ptr];
   assign wb_rd        = r_data_mem[r_rd_ptr];
   assign count        = r_count;

   assign w_push = result_valid & result_ready;
   assign w_pop  = wb_ack & wb_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Storage carries no reset; contents are meaningless while wb_done is low.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_id_mem[r_wr_ptr]   <= result_id;
         r_data_mem[r_wr_ptr] <= result_data;
      end
   end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed bench for wb_result_buffer (DEPTH=2): reset, single result, backpressure,
// streaming with wrap, simultaneous push/pop, spurious ack and asynchronous reset.
module tb_wb_result_buffer;

   localparam int DEPTH = 2;
   localparam int ID_W  = 4;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            result_valid = 1'b0;
   logic [ID_W-1:0] result_id = '0;
   logic [XLEN-1:0] result_data = '0;
   logic            result_ready;
   logic            wb_done;
   logic [ID_W-1:0] wb_id;
   logic [XLEN-1:0] wb_rd;
   logic            wb_ack = 1'b0;
   logic [1:0]      count;

   int n_vec = 0;
   int n_err = 0;
   logic [ID_W-1:0] exp_q[$];
   int wb_seen;
   int budget;

   wb_result_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .result_valid(result_valid), .result_id(result_id), .result_data(result_data),
      .result_ready(result_ready),
      .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      #2;
      check("rst_done", 64'(wb_done), 64'd0);
      check("rst_ready", 64'(result_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_count", 64'(count), 64'd0);

      // single result
      result_valid = 1'b1; result_id = 4'd3; result_data = 32'hDEADBEEF;
      step();
      result_valid = 1'b0;
      check("single_done", 64'(wb_done), 64'd1);
      check("single_id", 64'(wb_id), 64'd3);
      check("single_rd", 64'(wb_rd), 64'hDEADBEEF);
      check("single_count", 64'(count), 64'd1);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      check("single_pop_done", 64'(wb_done), 64'd0);
      check("single_pop_count", 64'(count), 64'd0);

      // fill and backpressure
      result_valid = 1'b1; result_id = 4'd1; result_data = 32'h0000_0011;
      step();
      result_id = 4'd2; result_data = 32'h0000_0022;
      step();
      result_id = 4'd3; result_data = 32'h0000_0033;
      check("full_count", 64'(count), 64'd2);
      check("full_ready", 64'(result_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("held_ready", 64'(result_ready), 64'd0);
         check("held_count", 64'(count), 64'd2);
         check("held_head", 64'(wb_id), 64'd1);
      end
      wb_ack = 1'b1;
      check("bp_out1_id", 64'(wb_id), 64'd1);
      check("bp_out1_rd", 64'(wb_rd), 64'h11);
      step();
      check("bp_ready_back", 64'(result_ready), 64'd1);
      check("bp_count1", 64'(count), 64'd1);
      check("bp_out2_id", 64'(wb_id), 64'd2);
      check("bp_out2_rd", 64'(wb_rd), 64'h22);
      step();
      result_valid = 1'b0;
      check("bp_id3_count", 64'(count), 64'd1);
      check("bp_id3_head", 64'(wb_id), 64'd3);
      check("bp_id3_rd", 64'(wb_rd), 64'h33);
      step();
      wb_ack = 1'b0;
      check("bp_drained", 64'(count), 64'd0);

      // streaming ids 0..15 with ack on done
      wb_seen = 0;
      for (int i = 0; i < 16; i++) begin
         result_valid = 1'b1;
         result_id = 4'(i);
         result_data = 32'h1000 + 32'(i);
         wb_ack = wb_done;
         if (wb_done) begin
            check("stream_id", 64'(wb_id), 64'(exp_q[0]));
            void'(exp_q.pop_front());
            wb_seen++;
         end
         check("stream_ready", 64'(result_ready), 64'd1);
         exp_q.push_back(4'(i));
         step();
         check("stream_count_le1", 64'(count <= 2'd1), 64'd1);
      end
      result_valid = 1'b0;
      budget = 10;
      while (wb_done && budget > 0) begin
         wb_ack = 1'b1;
         check("stream_tail_id", 64'(wb_id), 64'(exp_q[0]));
         void'(exp_q.pop_front());
         wb_seen++;
         step();
         budget--;
      end
      wb_ack = 1'b0;
      check("stream_total", 64'(wb_seen), 64'd16);
      check("stream_empty", 64'(count), 64'd0);

      // simultaneous push and pop at count=1
      result_valid = 1'b1; result_id = 4'd4; result_data = 32'h44;
      step();
      result_id = 4'd5; result_data = 32'h55; wb_ack = 1'b1;
      check("pp_head4", 64'(wb_id), 64'd4);
      step();
      result_valid = 1'b0;
      check("pp_count", 64'(count), 64'd1);
      check("pp_head5", 64'(wb_id), 64'd5);
      check("pp_rd5", 64'(wb_rd), 64'h55);
      step();
      wb_ack = 1'b0;
      check("pp_drained", 64'(count), 64'd0);

      // spurious ack on empty buffer
      wb_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("spur_count", 64'(count), 64'd0);
         check("spur_done", 64'(wb_done), 64'd0);
      end
      wb_ack = 1'b0;
      result_valid = 1'b1; result_id = 4'd7; result_data = 32'h77;
      step();
      result_valid = 1'b0;
      check("spur_push_done", 64'(wb_done), 64'd1);
      check("spur_push_id", 64'(wb_id), 64'd7);
      check("spur_push_count", 64'(count), 64'd1);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;

      // asynchronous reset mid-operation
      result_valid = 1'b1; result_id = 4'd10; result_data = 32'hA;
      step();
      result_id = 4'd11; result_data = 32'hB;
      step();
      result_valid = 1'b0;
      check("ar_pre_count", 64'(count), 64'd2);
      #2 rst = 1'b1;
      #1;
      check("ar_done", 64'(wb_done), 64'd0);
      check("ar_ready", 64'(result_ready), 64'd1);
      check("ar_count", 64'(count), 64'd0);
      #1 rst = 1'b0;
      result_valid = 1'b1; result_id = 4'd9; result_data = 32'h99;
      step();
      result_valid = 1'b0;
      check("ar_push_id", 64'(wb_id), 64'd9);
      check("ar_push_rd", 64'(wb_rd), 64'h99);
      check("ar_push_count", 64'(count), 64'd1);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      check("ar_final_done", 64'(wb_done), 64'd0);
      check("ar_final_count", 64'(count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
